ghost_mode_ctrl: RTL and testbench

GHOST_MODE_CTRL -- requirements
Module: ghost_mode_ctrl

---
 rtl/pac_pkg.sv | 26 ++
 rtl/ghost_mode_ctrl_if.sv | 31 +++
 rtl/frame_timer.sv | 31 +++
 rtl/ghost_mode_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ghost_mode_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pac_pkg.sv
// Shared ghost-mode types, screen limits and frame-count helpers.
package pac_pkg;

  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    CHASE   = 2'd1,
    FRIGHT  = 2'd2,
    EATEN   = 2'd3
  } ghost_mode_t;

  localparam int unsigned SCREEN_MAX_X = 639;
  localparam int unsigned SCREEN_MAX_Y = 479;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned TIMER_W      = 11;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // A zero duration would never expire, so it is promoted to one frame.
  function automatic logic [TIMER_W-1:0] frames_to_timer(input int unsigned frames);
    return (frames == 0) ? TIMER_W'(1) : TIMER_W'(frames);
  endfunction

endpackage

// File: rtl/ghost_mode_ctrl_if.sv
// Game-side signals seen by the ghost mode controller.
interface ghost_mode_ctrl_if;
  import pac_pkg::*;

  logic [COORD_W-1:0] pacX;
  logic [COORD_W-1:0] pacY;
  logic [COORD_W-1:0] ghostX;
  logic [COORD_W-1:0] ghostY;
  logic               power_pellet;
  logic               collide;
  logic               game_stop;

  logic [COORD_W-1:0] targetX;
  logic [COORD_W-1:0] targetY;
  logic [1:0]         mode;
  logic               frightened;
  logic               ghost_eaten;
  logic               pac_killed;
  logic               stop;

  modport master (
    output pacX, pacY, ghostX, ghostY, power_pellet, collide, game_stop,
    input  targetX, targetY, mode, frightened, ghost_eaten, pac_killed, stop
  );

  modport slave (
    input  pacX, pacY, ghostX, ghostY, power_pellet, collide, game_stop,
    output targetX, targetY, mode, frightened, ghost_eaten, pac_killed, stop
  );

endinterface

// File: rtl/frame_timer.sv
// Loadable, pausable frame down-counter that parks at 1 instead of underflowing.
module frame_timer #(
  parameter int unsigned         TIMER_W   = 11,
  parameter logic [TIMER_W-1:0]  RESET_VAL = TIMER_W'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               pause,
  output logic [TIMER_W-1:0] count,
  output logic               expire
);

  logic [TIMER_W-1:0] r_count;

  // Load wins over pause; counting stops at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RESET_VAL;
    end else if (load) begin
      r_count <= load_val;
    end else if (!pause && (r_count > TIMER_W'(1))) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign count  = r_count;
  assign expire = (r_count == TIMER_W'(1));

endmodule

// File: rtl/ghost_mode_ctrl.sv
// Ghost behaviour mode sequencer: scatter/chase schedule, fright, eaten return and kill latch.
module ghost_mode_ctrl
  import pac_pkg::*;
#(
  parameter int unsigned SCATTER_FRAMES = 420,
  parameter int unsigned CHASE_FRAMES   = 1200,
  parameter int unsigned FRIGHT_FRAMES  = 360,
  parameter int unsigned NUM_SWITCHES   = 7,
  parameter int unsigned CORNER_X       = 596,
  parameter int unsigned CORNER_Y       = 20,
  parameter int unsigned HOME_X         = 320,
  parameter int unsigned HOME_Y         = 236
) (
  input logic              frame_clk,
  input logic              Reset,
  ghost_mode_ctrl_if.slave bus
);

  localparam logic [TIMER_W-1:0] SCAT_T   = frames_to_timer(SCATTER_FRAMES);
  localparam logic [TIMER_W-1:0] CHASE_T  = frames_to_timer(CHASE_FRAMES);
  localparam logic [TIMER_W-1:0] FRIGHT_T = frames_to_timer(FRIGHT_FRAMES);
  localparam int unsigned        SW_W     = (NUM_SWITCHES < 1) ? 1 : $clog2(NUM_SWITCHES + 1);
  localparam logic [SW_W-1:0]    SW_MAX   = SW_W'(NUM_SWITCHES);

  ghost_mode_t        r_state, r_saved_mode, r_mode;
  logic [SW_W-1:0]    r_sw_cnt;
  logic [TIMER_W-1:0] r_saved_timer;
  logic               r_collide_q, r_stop;
  logic [COORD_W-1:0] r_target_x, r_target_y;
  logic               r_frightened, r_ghost_eaten, r_pac_killed;

  ghost_mode_t        w_next_state, w_timed_mode;
  logic [SW_W-1:0]    w_next_sw;
  logic [TIMER_W-1:0] w_count, w_load_val, w_timed_timer;
  logic               w_expire, w_load, w_pause, w_timed_switch;
  logic               w_save, w_ghost_eaten, w_pac_killed, w_set_stop;
  logic               w_collide_edge, w_at_home;
  coord_t             w_target;

  frame_timer #(
    .TIMER_W   (TIMER_W),
    .RESET_VAL (SCAT_T)
  ) u_timer (
    .clk      (frame_clk),
    .rst      (Reset),
    .load     (w_load),
    .load_val (w_load_val),
    .pause    (w_pause),
    .count    (w_count),
    .expire   (w_expire)
  );

  assign w_collide_edge = bus.collide & ~r_collide_q;
  assign w_at_home      = (bus.ghostX == COORD_W'(HOME_X)) && (bus.ghostY == COORD_W'(HOME_Y));

  // Where the scatter/chase schedule would go this frame; also the value saved on a pellet.
  always_comb begin
    w_timed_switch = 1'b0;
    w_timed_mode   = r_state;
    w_timed_timer  = w_count;
    if (w_expire) begin
      if (r_state == SCATTER) begin
        w_timed_switch = 1'b1;
        w_timed_mode   = CHASE;
        w_timed_timer  = CHASE_T;
      end else if ((r_state == CHASE) && (r_sw_cnt < SW_MAX)) begin
        w_timed_switch = 1'b1;
        w_timed_mode   = SCATTER;
        w_timed_timer  = SCAT_T;
      end
    end
  end

  // Mode transitions, timer control and event pulses.
  always_comb begin
    w_next_state  = r_state;
    w_next_sw     = r_sw_cnt;
    w_load        = 1'b0;
    w_load_val    = w_count;
    w_pause       = 1'b0;
    w_save        = 1'b0;
    w_ghost_eaten = 1'b0;
    w_pac_killed  = 1'b0;
    w_set_stop    = 1'b0;
    if (bus.game_stop) begin
      w_pause = 1'b1;
    end else begin
      case (r_state)
        SCATTER, CHASE: begin
          if (w_timed_switch && (r_sw_cnt != SW_MAX)) begin
            w_next_sw = r_sw_cnt + SW_W'(1);
          end
          if (bus.power_pellet) begin
            w_save = 1'b1;
            if (w_collide_edge) begin
              w_next_state  = EATEN;
              w_ghost_eaten = 1'b1;
              w_pause       = 1'b1;
            end else begin
              w_next_state = FRIGHT;
              w_load       = 1'b1;
              w_load_val   = FRIGHT_T;
            end
          end else begin
            if (w_collide_edge) begin
              w_pac_killed = 1'b1;
              w_set_stop   = 1'b1;
            end
            w_next_state = w_timed_mode;
            if (w_timed_switch) begin
              w_load     = 1'b1;
              w_load_val = w_timed_timer;
            end else if ((r_state == CHASE) && (r_sw_cnt == SW_MAX)) begin
              w_pause = 1'b1;
            end
          end
        end
        FRIGHT: begin
          if (w_collide_edge) begin
            w_next_state  = EATEN;
            w_ghost_eaten = 1'b1;
            w_pause       = 1'b1;
          end else if (bus.power_pellet) begin
            w_load     = 1'b1;
            w_load_val = FRIGHT_T;
          end else if (w_expire) begin
            w_next_state = r_saved_mode;
            w_load       = 1'b1;
            w_load_val   = r_saved_timer;
          end
        end
        EATEN: begin
          w_pause = 1'b1;
          if (w_at_home) begin
            w_next_state = r_saved_mode;
            w_load       = 1'b1;
            w_load_val   = r_saved_timer;
          end
        end
        default: ;
      endcase
    end
  end

  // Target for the mode the ghost is entering.
  always_comb begin
    w_target.x = COORD_W'(CORNER_X);
    w_target.y = COORD_W'(CORNER_Y);
    case (w_next_state)
      CHASE: begin
        w_target.x = bus.pacX;
        w_target.y = bus.pacY;
      end
      FRIGHT: begin
        w_target.x = COORD_W'(SCREEN_MAX_X) - bus.pacX;
        w_target.y = COORD_W'(SCREEN_MAX_Y) - bus.pacY;
      end
      EATEN: begin
        w_target.x = COORD_W'(HOME_X);
        w_target.y = COORD_W'(HOME_Y);
      end
      default: ;
    endcase
  end

  // State, saved pair, kill latch and registered outputs.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state       <= SCATTER;
      r_sw_cnt      <= '0;
      r_saved_mode  <= SCATTER;
      r_saved_timer <= SCAT_T;
      r_collide_q   <= 1'b0;
      r_stop        <= 1'b0;
      r_target_x    <= COORD_W'(CORNER_X);
      r_target_y    <= COORD_W'(CORNER_Y);
      r_mode        <= SCATTER;
      r_frightened  <= 1'b0;
      r_ghost_eaten <= 1'b0;
      r_pac_killed  <= 1'b0;
    end else begin
      r_collide_q <= bus.collide;
      r_state     <= w_next_state;
      r_sw_cnt    <= w_next_sw;
      if (w_save) begin
        r_saved_mode  <= w_timed_mode;
        r_saved_timer <= w_timed_timer;
      end
      if (w_set_stop) begin
        r_stop <= 1'b1;
      end
      r_target_x    <= w_target.x;
      r_target_y    <= w_target.y;
      r_mode        <= w_next_state;
      r_frightened  <= (w_next_state == FRIGHT);
      r_ghost_eaten <= w_ghost_eaten;
      r_pac_killed  <= w_pac_killed;
    end
  end

  assign bus.targetX     = r_target_x;
  assign bus.targetY     = r_target_y;
  assign bus.mode        = r_mode;
  assign bus.frightened  = r_frightened;
  assign bus.ghost_eaten = r_ghost_eaten;
  assign bus.pac_killed  = r_pac_killed;
  assign bus.stop        = r_stop | bus.game_stop;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed vector bench for ghost_mode_ctrl with short mode durations.
module tb_ghost_mode_ctrl;

  localparam int SC = 0;
  localparam int CH = 1;
  localparam int FR = 2;
  localparam int EA = 3;

  typedef struct {
    string      name;
    bit         rst;
    logic [9:0] px, py, gx, gy;
    bit         pel, col, gs;
    logic [1:0] e_mode;
    logic [9:0] e_tx, e_ty;
    bit         e_fr, e_ge, e_pk, e_stop;
  } vec_t;

  logic frame_clk;
  logic Reset;
  ghost_mode_ctrl_if bus ();

  vec_t  vecs[$];
  string cur_name;
  int    n_vec;
  int    n_miss;
  int    trk_x[8];
  int    trk_y[8];
  bit    done;

  ghost_mode_ctrl #(
    .SCATTER_FRAMES (4),
    .CHASE_FRAMES   (6),
    .FRIGHT_FRAMES  (3),
    .NUM_SWITCHES   (2)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Watchdog: the vector sequence must complete within a bounded wait.
  initial begin
    done = 1'b0;
    #200000;
    if (!done) begin
      $display("FAIL watchdog: vector sequence did not complete within the wait limit");
      $finish;
    end
  end

  function automatic void add(input bit rst, input int px, input int py, input int gx, input int gy,
                              input bit pel, input bit col, input bit gs,
                              input int m, input int tx, input int ty,
                              input bit fr, input bit ge, input bit pk, input bit st);
    vec_t v;
    v.name = cur_name;
    v.rst = rst;
    v.px = 10'(px); v.py = 10'(py); v.gx = 10'(gx); v.gy = 10'(gy);
    v.pel = pel; v.col = col; v.gs = gs;
    v.e_mode = 2'(m); v.e_tx = 10'(tx); v.e_ty = 10'(ty);
    v.e_fr = fr; v.e_ge = ge; v.e_pk = pk; v.e_stop = st;
    vecs.push_back(v);
  endfunction

  initial begin
    Reset            = 1'b1;
    bus.pacX         = '0;
    bus.pacY         = '0;
    bus.ghostX       = '0;
    bus.ghostY       = '0;
    bus.power_pellet = 1'b0;
    bus.collide      = 1'b0;
    bus.game_stop    = 1'b0;
    n_vec            = 0;
    n_miss           = 0;
    trk_x = '{639, 0, 1, 320, 638, 5, 7, 9};
    trk_y = '{479, 0, 2, 240, 478, 6, 8, 10};

    // Schedule: 4 scatter, 6 chase, 4 scatter, then chase for good.
    cur_name = "sched";
    add(1, 10, 11, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 10, 11, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 30, 31, 0, 0, 0, 0, 0, CH, 30, 31, 0, 0, 0, 0);
    add(0, 40, 41, 0, 0, 0, 0, 0, CH, 40, 41, 0, 0, 0, 0);
    add(0, 50, 51, 0, 0, 0, 0, 0, CH, 50, 51, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 60, 61, 0, 0, 0, 0, 0, CH, 60, 61, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 70, 71, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 80, 81, 0, 0, 0, 0, 0, CH, 80, 81, 0, 0, 0, 0);
    cur_name = "perm_chase";
    for (int k = 0; k < 8; k++)
      add(0, trk_x[k], trk_y[k], 0, 0, 0, 0, 0, CH, trk_x[k], trk_y[k], 0, 0, 0, 0);

    // Pellet with 4 chase frames left; chase resumes with those 4 frames.
    cur_name = "fright_resume";
    add(1, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 100, 50, 0, 0, 0, 0, 0, CH, 100, 50, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 1, 0, 0, FR, 539, 429, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) add(0, 100, 50, 0, 0, 0, 0, 0, FR, 539, 429, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 100, 50, 0, 0, 0, 0, 0, CH, 100, 50, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);

    // Frightened ghost is eaten, returns home, scatter resumes with a paused timer.
    cur_name = "eaten";
    add(1, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 1, 0, 0, FR, 539, 429, 1, 0, 0, 0);
    add(0, 100, 50, 0, 0, 0, 1, 0, EA, 320, 236, 0, 1, 0, 0);
    add(0, 100, 50, 0, 0, 1, 1, 0, EA, 320, 236, 0, 0, 0, 0);
    add(0, 100, 50, 320, 0, 0, 1, 0, EA, 320, 236, 0, 0, 0, 0);
    add(0, 100, 50, 320, 236, 0, 1, 0, SC, 596, 20, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 0, 0, 0, CH, 100, 50, 0, 0, 0, 0);

    // Contact outside fright kills Pac-Man once; stop holds until reset.
    cur_name = "killed";
    add(1, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 0, 1, 0, SC, 596, 20, 0, 0, 1, 1);
    for (int k = 0; k < 2; k++) add(0, 100, 50, 0, 0, 0, 1, 0, SC, 596, 20, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) add(0, 100, 50, 0, 0, 0, 0, 0, CH, 100, 50, 0, 0, 0, 1);
    add(1, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);

    // Pellet and contact together eat the ghost; then a 10-frame freeze.
    cur_name = "pellet_collide";
    add(1, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 1, 1, 0, EA, 320, 236, 0, 1, 0, 0);
    add(0, 100, 50, 320, 236, 0, 1, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 100, 50, 320, 236, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    cur_name = "freeze";
    for (int k = 0; k < 10; k++) add(0, 100, 50, 0, 0, 0, 1, 1, SC, 596, 20, 0, 0, 0, 1);
    add(0, 100, 50, 0, 0, 0, 1, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 0, 0, 0, CH, 100, 50, 0, 0, 0, 0);

    // A second pellet in fright restarts the fright timer only.
    cur_name = "fright_reload";
    add(1, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 1, 0, 0, FR, 539, 429, 1, 0, 0, 0);
    add(0, 100, 50, 0, 0, 0, 0, 0, FR, 539, 429, 1, 0, 0, 0);
    add(0, 100, 50, 0, 0, 1, 0, 0, FR, 539, 429, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) add(0, 100, 50, 0, 0, 0, 0, 0, FR, 539, 429, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 0, 0, 0, CH, 100, 50, 0, 0, 0, 0);

    // Pellet on the scatter expiry frame saves chase with its full duration.
    cur_name = "expire_pellet";
    add(1, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 1, 0, 0, FR, 539, 429, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) add(0, 100, 50, 0, 0, 0, 0, 0, FR, 539, 429, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) add(0, 100, 50, 0, 0, 0, 0, 0, CH, 100, 50, 0, 0, 0, 0);
    add(0, 100, 50, 0, 0, 0, 0, 0, SC, 596, 20, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [25:0] got;
      logic [25:0] exp_v;
      Reset            = vecs[i].rst;
      bus.pacX         = vecs[i].px;
      bus.pacY         = vecs[i].py;
      bus.ghostX       = vecs[i].gx;
      bus.ghostY       = vecs[i].gy;
      bus.power_pellet = vecs[i].pel;
      bus.collide      = vecs[i].col;
      bus.game_stop    = vecs[i].gs;
      @(posedge frame_clk);
      #1;
      got   = {bus.mode, bus.targetX, bus.targetY, bus.frightened,
               bus.ghost_eaten, bus.pac_killed, bus.stop};
      exp_v = {vecs[i].e_mode, vecs[i].e_tx, vecs[i].e_ty, vecs[i].e_fr,
               vecs[i].e_ge, vecs[i].e_pk, vecs[i].e_stop};
      n_vec++;
      if (got !== exp_v) begin
        n_miss++;
        $display("FAIL %s vec%0d: got mode=%0d tx=%0d ty=%0d fr=%0b ge=%0b pk=%0b stop=%0b, required mode=%0d tx=%0d ty=%0d fr=%0b ge=%0b pk=%0b stop=%0b",
                 vecs[i].name, i, bus.mode, bus.targetX, bus.targetY, bus.frightened,
                 bus.ghost_eaten, bus.pac_killed, bus.stop,
                 vecs[i].e_mode, vecs[i].e_tx, vecs[i].e_ty, vecs[i].e_fr,
                 vecs[i].e_ge, vecs[i].e_pk, vecs[i].e_stop);
      end
    end

    // Reset wins over simultaneous pellet, contact and freeze, and restores every output.
    Reset            = 1'b1;
    bus.pacX         = 10'(100);
    bus.pacY         = 10'(50);
    bus.power_pellet = 1'b1;
    bus.collide      = 1'b1;
    bus.game_stop    = 1'b1;
    @(posedge frame_clk);
    #1;
    n_vec++;
    if ((bus.mode !== 2'(SC)) || (bus.targetX !== 10'(596)) || (bus.targetY !== 10'(20)) ||
        (bus.frightened !== 1'b0) || (bus.ghost_eaten !== 1'b0) || (bus.pac_killed !== 1'b0)) begin
      n_miss++;
      $display("FAIL reset_state: got mode=%0d tx=%0d ty=%0d fr=%0b ge=%0b pk=%0b, required mode=0 tx=596 ty=20 fr=0 ge=0 pk=0",
               bus.mode, bus.targetX, bus.targetY, bus.frightened, bus.ghost_eaten, bus.pac_killed);
    end
    bus.game_stop    = 1'b0;
    bus.power_pellet = 1'b0;
    @(posedge frame_clk);
    #1;
    n_vec++;
    if ((bus.stop !== 1'b0) || (bus.mode !== 2'(SC))) begin
      n_miss++;
      $display("FAIL reset_stop: got stop=%0b mode=%0d, required stop=0 mode=0", bus.stop, bus.mode);
    end
    Reset       = 1'b0;
    bus.collide = 1'b0;

    done = 1'b1;
    if (n_miss == 0)
      $display("PASS == %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    else
      $display("FAIL == %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
